// File: rtl/regex_cpu_pipelined.sv
// Pipelined regex thread executor.
// A thread (pc, cc_id) is accepted, its instruction word is fetched from
// external memory, executed against the current character of stream cc_id,
// and any successor threads are pushed into a small output FIFO.
// Optional feature macro: REGEX_CPU_ACCEPT_PARTIAL_EN (ACCEPT_PARTIAL opcode
// accepts unconditionally when defined, is treated as reserved otherwise).

package instruction_package;
  localparam logic [2:0] OP_ACCEPT         = 3'b000;
  localparam logic [2:0] OP_SPLIT          = 3'b001;
  localparam logic [2:0] OP_MATCH_CHAR     = 3'b010;
  localparam logic [2:0] OP_MATCH_ANY      = 3'b011;
  localparam logic [2:0] OP_JMP            = 3'b100;
  localparam logic [2:0] OP_ACCEPT_PARTIAL = 3'b101;
endpackage

module regex_cpu_pipelined
  import instruction_package::*;
#(
  parameter int PC_WIDTH              = 9,
  parameter int CHARACTER_WIDTH       = 8,
  parameter int MEMORY_WIDTH          = 20,
  parameter int MEMORY_ADDR_WIDTH     = 11,
  parameter int FIFO_WIDTH_POWER_OF_2 = 2,
  parameter int CC_ID_BITS            = 2,
  localparam int N_CC                 = 1 << CC_ID_BITS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_CC*CHARACTER_WIDTH-1:0]   current_characters,
  input  logic [N_CC-1:0]                   end_of_string,
  input  logic                              input_pc_valid,
  input  logic [CC_ID_BITS-1:0]             input_cc_id,
  input  logic [PC_WIDTH-1:0]               input_pc,
  output logic                              input_pc_ready,
  output logic                              memory_valid,
  output logic [MEMORY_ADDR_WIDTH-1:0]      memory_addr,
  input  logic                              memory_ready,
  input  logic [MEMORY_WIDTH-1:0]           memory_data,
  output logic                              output_pc_valid,
  output logic [CC_ID_BITS-1:0]             output_cc_id,
  output logic [PC_WIDTH-1:0]               output_pc,
  input  logic                              output_pc_ready,
  output logic                              accepts,
  output logic [N_CC-1:0]                   elaborating_chars,
  output logic                              running
);

  localparam int FW    = FIFO_WIDTH_POWER_OF_2;
  localparam int DEPTH = 1 << FW;
  localparam int IDW   = MEMORY_WIDTH - 3;
  // in-flight entries per stream never exceed FIFO depth plus the executing thread
  localparam int CNT_W = FW + 2;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} state_t;

  state_t                  state_q;
  logic [PC_WIDTH-1:0]     pc_q;
  logic [CC_ID_BITS-1:0]   cc_q;
  logic [MEMORY_WIDTH-1:0] instr_q;
  logic                    exec_first_q;

  logic [PC_WIDTH-1:0]     fifo_pc [DEPTH];
  logic [CC_ID_BITS-1:0]   fifo_cc [DEPTH];
  logic [FW-1:0]           rd_ptr, wr_ptr;
  logic [FW:0]             fifo_cnt;

  // memory_data is only valid in the first execute cycle; a stalled execute
  // replays the copy captured on that cycle's edge
  logic [MEMORY_WIDTH-1:0]  instr;
  logic [2:0]               op;
  logic [IDW-1:0]           data;
  logic [CHARACTER_WIDTH-1:0] cur_char;
  logic                     cur_eos;
  logic [PC_WIDTH-1:0]      pc_inc, push_pc0, push_pc1;
  logic [1:0]               n_push, need, push_cnt;
  logic                     do_acc, exec_go, pop, accept_in;
  logic [FW+1:0]            free;
  logic                     unused_bits;

  assign instr       = exec_first_q ? memory_data : instr_q;
  assign op          = instr[MEMORY_WIDTH-1 -: 3];
  assign data        = instr[IDW-1:0];
  assign unused_bits = ^data[IDW-1:PC_WIDTH];
  assign cur_char    = current_characters[cc_q*CHARACTER_WIDTH +: CHARACTER_WIDTH];
  assign cur_eos     = end_of_string[cc_q];
  assign pc_inc      = pc_q + 1'b1;

  assign memory_addr     = {{(MEMORY_ADDR_WIDTH-PC_WIDTH){1'b0}}, pc_q};
  assign output_pc_valid = (fifo_cnt != '0);
  assign output_pc       = fifo_pc[rd_ptr];
  assign output_cc_id    = fifo_cc[rd_ptr];
  assign pop             = output_pc_valid && output_pc_ready;
  assign accept_in       = input_pc_valid && input_pc_ready;
  // a same-cycle pop frees a slot, so a full FIFO can still take a push
  assign free            = (FW+2)'(DEPTH) - {1'b0, fifo_cnt} + (FW+2)'(pop);
  assign exec_go         = (state_q == S_EXEC) && (free >= (FW+2)'(need));
  assign push_cnt        = exec_go ? n_push : 2'd0;

  // decode: successor count/pcs and accept for the executing thread
  always_comb begin
    n_push   = 2'd0;
    need     = 2'd1;
    push_pc0 = pc_inc;
    push_pc1 = data[PC_WIDTH-1:0];
    do_acc   = 1'b0;
    case (op)
      OP_JMP: begin
        n_push   = 2'd1;
        push_pc0 = data[PC_WIDTH-1:0];
      end
      OP_ACCEPT:     do_acc = cur_eos;
      OP_MATCH_CHAR: if (!cur_eos && cur_char == data[CHARACTER_WIDTH-1:0]) n_push = 2'd1;
      OP_MATCH_ANY:  if (!cur_eos) n_push = 2'd1;
      OP_SPLIT: begin
        n_push = 2'd2;
        need   = 2'd2;
      end
`ifdef REGEX_CPU_ACCEPT_PARTIAL_EN
      OP_ACCEPT_PARTIAL: do_acc = 1'b1;
`else
      OP_ACCEPT_PARTIAL: do_acc = 1'b0;
`endif
      default: ;
    endcase
  end

  // thread FSM: idle -> fetch (request held until handshake) -> execute
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      input_pc_ready <= 1'b1;
      memory_valid   <= 1'b0;
      pc_q           <= '0;
      cc_q           <= '0;
      instr_q        <= '0;
      exec_first_q   <= 1'b0;
      accepts        <= 1'b0;
    end else begin
      accepts <= 1'b0;
      case (state_q)
        S_IDLE: if (accept_in) begin
          pc_q           <= input_pc;
          cc_q           <= input_cc_id;
          input_pc_ready <= 1'b0;
          memory_valid   <= 1'b1;
          state_q        <= S_FETCH;
        end
        S_FETCH: if (memory_ready) begin
          memory_valid <= 1'b0;
          exec_first_q <= 1'b1;
          state_q      <= S_EXEC;
        end
        S_EXEC: begin
          exec_first_q <= 1'b0;
          if (exec_first_q) instr_q <= memory_data;
          if (exec_go) begin
            accepts        <= do_acc;
            input_pc_ready <= 1'b1;
            state_q        <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // output FIFO: up to two pushes (SPLIT) and one pop per cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc[i] <= '0;
        fifo_cc[i] <= '0;
      end
    end else begin
      if (push_cnt != 2'd0) begin
        fifo_pc[wr_ptr] <= push_pc0;
        fifo_cc[wr_ptr] <= cc_q;
      end
      if (push_cnt == 2'd2) begin
        fifo_pc[FW'(wr_ptr + 1'b1)] <= push_pc1;
        fifo_cc[FW'(wr_ptr + 1'b1)] <= cc_q;
      end
      wr_ptr   <= wr_ptr + FW'(push_cnt);
      rd_ptr   <= rd_ptr + FW'(pop);
      fifo_cnt <= fifo_cnt + (FW+1)'(push_cnt) - (FW+1)'(pop);
    end
  end

  // per-stream count of threads in the pipeline or the FIFO
  for (genvar g = 0; g < N_CC; g++) begin : g_cc
    logic [CNT_W-1:0] cnt_q, inc, dec;
    logic             here;

    assign here = (cc_q == CC_ID_BITS'(g));
    assign inc  = CNT_W'(accept_in && input_cc_id == CC_ID_BITS'(g))
                + (here ? CNT_W'(push_cnt) : '0);
    assign dec  = CNT_W'(exec_go && here)
                + CNT_W'(pop && output_cc_id == CC_ID_BITS'(g));
    assign elaborating_chars[g] = (cnt_q != '0);

    // add arrivals/successors, retire executed and popped threads
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_q + inc - dec;
    end
  end

  assign running = |elaborating_chars;

endmodule

// File: tb/tb_regex_cpu_pipelined.sv
// Directed bench for regex_cpu_pipelined: JMP sweep, MATCH_CHAR, ACCEPT,
// SPLIT ordering, FIFO backpressure and mid-fetch reset.
module tb_regex_cpu_pipelined;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] current_characters;
  logic [3:0]  end_of_string;
  logic        input_pc_valid;
  logic [1:0]  input_cc_id;
  logic [8:0]  input_pc;
  logic        input_pc_ready;
  logic        memory_valid;
  logic [10:0] memory_addr;
  logic        memory_ready;
  logic [19:0] memory_data = '0;
  logic        output_pc_valid;
  logic [1:0]  output_cc_id;
  logic [8:0]  output_pc;
  logic        output_pc_ready;
  logic        accepts;
  logic [3:0]  elaborating_chars;
  logic        running;

  logic [19:0] instr_word = '0;
  int vectors = 0;
  int fails   = 0;

  regex_cpu_pipelined dut (
    .clk(clk), .rst(rst),
    .current_characters(current_characters), .end_of_string(end_of_string),
    .input_pc_valid(input_pc_valid), .input_cc_id(input_cc_id), .input_pc(input_pc),
    .input_pc_ready(input_pc_ready),
    .memory_valid(memory_valid), .memory_addr(memory_addr),
    .memory_ready(memory_ready), .memory_data(memory_data),
    .output_pc_valid(output_pc_valid), .output_cc_id(output_cc_id), .output_pc(output_pc),
    .output_pc_ready(output_pc_ready),
    .accepts(accepts), .elaborating_chars(elaborating_chars), .running(running)
  );

  always #5 clk = ~clk;

  // instruction memory: word returned the cycle after the request handshake
  always @(posedge clk) if (memory_valid && memory_ready) memory_data <= instr_word;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] ins(input logic [2:0] op, input int d);
    return {op, 17'(d)};
  endfunction

  // offer a thread, then check the fetch request one cycle after acceptance
  task automatic send(input int cc, input int pc, input logic [19:0] word);
    logic ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (input_pc_ready) begin ok = 1'b1; break; end
    end
    chk("send_ready", 32'(ok), 1);
    instr_word     = word;
    input_cc_id    = 2'(cc);
    input_pc       = 9'(pc);
    input_pc_valid = 1'b1;
    @(negedge clk);
    input_pc_valid = 1'b0;
    chk("elab_set", 32'(elaborating_chars[cc]), 1);
    chk("mem_valid", 32'(memory_valid), 1);
    chk("mem_addr", 32'(memory_addr), 32'(11'(pc)));
  endtask

  task automatic wait_done();
    logic ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (input_pc_ready) begin ok = 1'b1; break; end
    end
    chk("exec_done", 32'(ok), 1);
  endtask

  task automatic pop(input int cc, input int pc);
    chk("pop_valid", 32'(output_pc_valid), 1);
    chk("pop_pc", 32'(output_pc), 32'(pc));
    chk("pop_cc", 32'(output_cc_id), 32'(cc));
    output_pc_ready = 1'b1;
    @(negedge clk);
    output_pc_ready = 1'b0;
  endtask

  task automatic wait_quiet();
    logic ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!running && !output_pc_valid && !memory_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("quiet", 32'(ok), 1);
  endtask

  initial begin
    rst = 1'b0;
    current_characters = '0;
    end_of_string = '0;
    input_pc_valid = 1'b0;
    input_cc_id = '0;
    input_pc = '0;
    memory_ready = 1'b1;
    output_pc_ready = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_in_ready", 32'(input_pc_ready), 1);
    chk("rst_mem_valid", 32'(memory_valid), 0);
    chk("rst_out_valid", 32'(output_pc_valid), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_accepts", 32'(accepts), 0);
    chk("rst_out_pc", 32'(output_pc), 0);
    rst = 1'b1;

    // JMP sweep across pc 245..311 and every stream
    for (int k = 0; k < 7; k++) begin
      int pc, tgt, cc;
      pc  = 245 + 11 * k;
      tgt = (k == 6) ? 309 : 220 + 13 * k;
      cc  = k % 4;
      send(cc, pc, ins(3'b100, tgt));
      wait_done();
      pop(cc, tgt);
      chk("jmp_single", 32'(output_pc_valid), 0);
      wait_quiet();
    end

    // MATCH_CHAR hit then miss
    current_characters[23:16] = 8'h61;
    send(2, 10, ins(3'b010, 'h61));
    wait_done();
    pop(2, 11);
    wait_quiet();
    current_characters[23:16] = 8'h62;
    send(2, 10, ins(3'b010, 'h61));
    wait_done();
    chk("mc_miss_out", 32'(output_pc_valid), 0);
    wait_quiet();

    // ACCEPT with and without end of string
    end_of_string = 4'b0010;
    send(1, 5, ins(3'b000, 0));
    wait_done();
    chk("acc_pulse", 32'(accepts), 1);
    chk("acc_no_out", 32'(output_pc_valid), 0);
    @(negedge clk);
    chk("acc_one_cycle", 32'(accepts), 0);
    end_of_string = 4'b0000;
    send(1, 5, ins(3'b000, 0));
    wait_done();
    chk("acc_no_eos", 32'(accepts), 0);
    wait_quiet();

    // SPLIT: two successors in order, head stable without pop
    send(3, 20, ins(3'b001, 40));
    wait_done();
    chk("split_head", 32'(output_pc), 21);
    @(negedge clk);
    @(negedge clk);
    chk("split_hold_pc", 32'(output_pc), 21);
    chk("split_hold_cc", 32'(output_cc_id), 3);
    pop(3, 21);
    pop(3, 40);
    chk("split_drained", 32'(output_pc_valid), 0);
    wait_quiet();

    // backpressure: fill the FIFO, fifth thread stalls in execute
    for (int k = 0; k < 4; k++) begin
      send(0, 100 + k, ins(3'b100, 200 + k));
      wait_done();
    end
    send(1, 104, ins(3'b100, 204));
    repeat (5) @(negedge clk);
    chk("bp_in_ready", 32'(input_pc_ready), 0);
    chk("bp_elab", 32'(elaborating_chars), 32'h3);
    for (int k = 0; k < 4; k++) pop(0, 200 + k);
    pop(1, 204);
    wait_quiet();

    // reset asserted while the fetch is held off by memory_ready
    memory_ready = 1'b0;
    send(0, 50, ins(3'b100, 60));
    @(negedge clk);
    @(negedge clk);
    chk("mid_mem_hold", 32'(memory_valid), 1);
    rst = 1'b0;
    #1;
    chk("mid_in_ready", 32'(input_pc_ready), 1);
    chk("mid_mem_valid", 32'(memory_valid), 0);
    chk("mid_out_valid", 32'(output_pc_valid), 0);
    chk("mid_elab", 32'(elaborating_chars), 0);
    chk("mid_running", 32'(running), 0);
    chk("mid_accepts", 32'(accepts), 0);
    @(negedge clk);
    rst = 1'b1;
    memory_ready = 1'b1;
    send(2, 77, ins(3'b100, 88));
    wait_done();
    pop(2, 88);
    wait_quiet();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
